// File: rtl/toggle_event_receiver.sv
// Toggle-encoded event receiver: synchronises req_tog, decodes each edge into an
// event, queues up to DEPTH of them for a valid/ready consumer and returns ack_tog.
module toggle_event_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH       = 4,
    parameter int CNT_W       = 3
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             req_tog,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic             ack_tog,
    output logic [CNT_W-1:0] pending,
    output logic             overflow
);

    typedef enum logic {
        PRIME,
        RUN
    } state_t;

    localparam int PW = $clog2(SYNC_STAGES + 1);
    localparam logic [PW-1:0] PRIME_LAST = PW'(SYNC_STAGES);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic                   s_d;
    logic                   detect;
    logic                   consume;

    state_t                 state;
    state_t                 state_nxt;
    logic [PW-1:0]          prime_cnt;
    logic [PW-1:0]          prime_cnt_nxt;
    logic [CNT_W-1:0]       pending_nxt;
    logic                   overflow_nxt;

    assign s         = sync[SYNC_STAGES-1];
    assign evt_valid = (pending != '0);
    assign consume   = evt_valid & evt_ready;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            sync <= '0;
            s_d  <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], req_tog};
            s_d  <= s;
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state     <= PRIME;
            prime_cnt <= '0;
            pending   <= '0;
            overflow  <= 1'b0;
            ack_tog   <= 1'b0;
        end else begin
            state     <= state_nxt;
            prime_cnt <= prime_cnt_nxt;
            pending   <= pending_nxt;
            overflow  <= overflow_nxt;
            ack_tog   <= ack_tog ^ consume;
        end
    end

    // PRIME masks detect until s_d has caught up with the level seen at release
    always_comb begin
        state_nxt     = state;
        prime_cnt_nxt = prime_cnt;
        detect        = 1'b0;
        pending_nxt   = pending;
        overflow_nxt  = overflow;
        unique case (state)
            PRIME: begin
                pending_nxt = '0;
                if (prime_cnt == PRIME_LAST) begin
                    state_nxt = RUN;
                end else begin
                    prime_cnt_nxt = prime_cnt + PW'(1);
                end
            end
            RUN: begin
                detect = s ^ s_d;
                case ({detect, consume})
                    2'b10: begin
                        if (pending < FULL) begin
                            pending_nxt = pending + CNT_W'(1);
                        end else begin
                            overflow_nxt = 1'b1;
                        end
                    end
                    2'b01:   pending_nxt = pending - CNT_W'(1);
                    default: pending_nxt = pending;
                endcase
            end
            default: state_nxt = PRIME;
        endcase
    end

endmodule

// File: tb/tb_toggle_event_receiver.sv
// Directed bench for toggle_event_receiver: vector table for priming,
// single event and overflow/drain, then hand sequences for the corner cases.
module tb_toggle_event_receiver;

    logic       clk;
    logic       clear_n;
    logic       req_tog;
    logic       evt_valid;
    logic       evt_ready;
    logic       ack_tog;
    logic [2:0] pending;
    logic       overflow;

    int total;
    int bad;

    typedef struct {
        logic       r;
        logic       rdy;
        logic       v;
        logic [2:0] p;
        logic       a;
        logic       o;
    } vec_t;

    vec_t tbl [26];

    toggle_event_receiver #(
        .SYNC_STAGES(2),
        .DEPTH      (4),
        .CNT_W      (3)
    ) dut (
        .clk      (clk),
        .clear_n  (clear_n),
        .req_tog  (req_tog),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .ack_tog  (ack_tog),
        .pending  (pending),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic rdy);
        @(negedge clk);
        req_tog   = r;
        evt_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic r);
        clear_n   = 1'b0;
        req_tog   = r;
        evt_ready = 1'b0;
        #12;
        @(negedge clk);
        clear_n = 1'b1;
    endtask

    initial begin
        int   acks;
        int   togs;
        int   pmax;
        logic prev_ack;
        logic prev_r;
        logic r;

        total = 0;
        bad   = 0;

        tbl[0]  = '{1, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 0, 0, 0, 0};
        tbl[2]  = '{1, 0, 0, 0, 0, 0};
        tbl[3]  = '{1, 0, 0, 0, 0, 0};
        tbl[4]  = '{1, 0, 0, 0, 0, 0};
        tbl[5]  = '{0, 1, 0, 0, 0, 0};
        tbl[6]  = '{0, 1, 0, 0, 0, 0};
        tbl[7]  = '{0, 1, 1, 1, 0, 0};
        tbl[8]  = '{0, 1, 0, 0, 1, 0};
        tbl[9]  = '{0, 1, 0, 0, 1, 0};
        tbl[10] = '{1, 0, 0, 0, 1, 0};
        tbl[11] = '{1, 0, 0, 0, 1, 0};
        tbl[12] = '{0, 0, 1, 1, 1, 0};
        tbl[13] = '{0, 0, 1, 1, 1, 0};
        tbl[14] = '{1, 0, 1, 2, 1, 0};
        tbl[15] = '{1, 0, 1, 2, 1, 0};
        tbl[16] = '{0, 0, 1, 3, 1, 0};
        tbl[17] = '{0, 0, 1, 3, 1, 0};
        tbl[18] = '{1, 0, 1, 4, 1, 0};
        tbl[19] = '{1, 0, 1, 4, 1, 0};
        tbl[20] = '{1, 0, 1, 4, 1, 1};
        tbl[21] = '{1, 1, 1, 3, 0, 1};
        tbl[22] = '{1, 1, 1, 2, 1, 1};
        tbl[23] = '{1, 1, 1, 1, 0, 1};
        tbl[24] = '{1, 1, 0, 0, 1, 1};
        tbl[25] = '{1, 1, 0, 0, 1, 1};

        // reset values while clear_n is held low, req_tog already high
        clear_n   = 1'b0;
        req_tog   = 1'b1;
        evt_ready = 1'b0;
        #3;
        chk("rst_valid", evt_valid, 0);
        chk("rst_pending", pending, 0);
        chk("rst_ack", ack_tog, 0);
        chk("rst_ovf", overflow, 0);
        #10;
        @(negedge clk);
        clear_n = 1'b1;

        // prime, single event, overflow and drain
        for (int i = 0; i < 26; i++) begin
            step(tbl[i].r, tbl[i].rdy);
            chk($sformatf("vec%0d_valid", i + 1), evt_valid, tbl[i].v);
            chk($sformatf("vec%0d_pending", i + 1), pending, tbl[i].p);
            chk($sformatf("vec%0d_ack", i + 1), ack_tog, tbl[i].a);
            chk($sformatf("vec%0d_ovf", i + 1), overflow, tbl[i].o);
        end

        // three more events queued, then asynchronous clear mid-cycle
        step(0, 0);
        step(0, 0);
        step(1, 0);
        step(1, 0);
        step(0, 0);
        step(0, 0);
        step(0, 0);
        step(0, 0);
        chk("mid_pending", pending, 3);
        chk("mid_ack", ack_tog, 1);
        chk("mid_ovf", overflow, 1);
        #3;
        clear_n = 1'b0;
        req_tog = 1'b1;
        #1;
        chk("async_valid", evt_valid, 0);
        chk("async_pending", pending, 0);
        chk("async_ack", ack_tog, 0);
        chk("async_ovf", overflow, 0);
        #12;
        @(negedge clk);
        clear_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1, 0);
            chk($sformatf("reprime%0d_valid", i), evt_valid, 0);
            chk($sformatf("reprime%0d_pending", i), pending, 0);
        end

        // full queue with detect and consume on the same edge
        do_reset(0);
        for (int i = 1; i <= 3; i++) step(0, 0);
        for (int i = 4; i <= 14; i++) begin
            r = (((i - 4) / 2) % 2 == 0);
            step(r, i == 14);
            if (i == 13) begin
                chk("full_pending", pending, 4);
                chk("full_ovf", overflow, 0);
            end
        end
        chk("both_pending", pending, 4);
        chk("both_ovf", overflow, 0);
        chk("both_ack", ack_tog, 1);

        // steady toggling with the consumer always ready
        do_reset(0);
        for (int i = 1; i <= 3; i++) step(0, 0);
        acks     = 0;
        togs     = 0;
        pmax     = 0;
        prev_ack = ack_tog;
        prev_r   = 1'b0;
        for (int i = 0; i < 46; i++) begin
            r = (i < 40) ? (((i / 2) % 2) == 0) : prev_r;
            if (r != prev_r) togs++;
            prev_r = r;
            step(r, 1);
            if (ack_tog != prev_ack) acks++;
            prev_ack = ack_tog;
            if (int'(pending) > pmax) pmax = int'(pending);
        end
        chk("steady_pmax", pmax, 1);
        chk("steady_acks", acks, togs);
        chk("steady_togs", togs, 20);
        chk("steady_pending", pending, 0);
        chk("steady_ovf", overflow, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
